// File: rtl/mtx_pkg.sv
// Shared types and constants for the 2x2 complex state matrix and its helpers.
// Elements are signed fixed point: sign, 1 integer bit, FRAC fraction bits.
package mtx_pkg;

  localparam int W    = 19;
  localparam int FRAC = 17;

  localparam logic signed [W-1:0] ONE = 19'h20000;

  localparam logic [1:0] OP_IDENT = 2'd0;
  localparam logic [1:0] OP_COPY  = 2'd1;
  localparam logic [1:0] OP_MULT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MAC    = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cplx_t;

  typedef cplx_t mat_t [2][2];

  localparam cplx_t CPLX_ZERO = '{re: '0, im: '0};
  localparam cplx_t CPLX_ONE  = '{re: ONE, im: '0};

  localparam mat_t MAT_IDENT = '{'{CPLX_ONE, CPLX_ZERO}, '{CPLX_ZERO, CPLX_ONE}};
  localparam mat_t MAT_ZERO  = '{'{CPLX_ZERO, CPLX_ZERO}, '{CPLX_ZERO, CPLX_ZERO}};

endpackage

// File: rtl/cplx_mul_round.sv
// Combinational complex multiply a*b plus a full-precision addend, then round
// half-up and reduce to W bits (clamped when MTX_SAT_EN is defined, else wrapped).
module cplx_mul_round
  import mtx_pkg::*;
(
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  input  logic signed [2*W:0] add_re,
  input  logic signed [2*W:0] add_im,
  output logic signed [2*W:0] sum_re,
  output logic signed [2*W:0] sum_im,
  output logic signed [W-1:0] res_re,
  output logic signed [W-1:0] res_im,
  output logic                sat_hit
);

  localparam int PW = 2 * W;
  localparam int SW = 2 * W + 2;

  localparam logic signed [SW-1:0] RND_BIAS = {{(SW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [SW-1:0] MAX_EXT  = {{(W+3){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_EXT  = {{(W+3){1'b1}}, {(W-1){1'b0}}};

  function automatic logic signed [PW-1:0] mul_full(input logic signed [W-1:0] x,
                                                    input logic signed [W-1:0] y);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ye;
    xe = {{W{x[W-1]}}, x};
    ye = {{W{y[W-1]}}, y};
    return xe * ye;
  endfunction

  function automatic logic signed [SW-1:0] round_half_up(input logic signed [SW-1:0] v);
    return (v + RND_BIAS) >>> FRAC;
  endfunction

  function automatic logic out_of_range(input logic signed [SW-1:0] v);
    return (v > MAX_EXT) || (v < MIN_EXT);
  endfunction

  function automatic logic signed [W-1:0] reduce(input logic signed [SW-1:0] v);
`ifdef MTX_SAT_EN
    if (v > MAX_EXT) return MAX_EXT[W-1:0];
    if (v < MIN_EXT) return MIN_EXT[W-1:0];
`endif
    return v[W-1:0];
  endfunction

  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PW:0]   prod_re, prod_im;
  logic signed [SW-1:0] full_re, full_im;
  logic signed [SW-1:0] rnd_re, rnd_im;

  always_comb begin
    p_rr    = mul_full(a_re, b_re);
    p_ii    = mul_full(a_im, b_im);
    p_ri    = mul_full(a_re, b_im);
    p_ir    = mul_full(a_im, b_re);
    prod_re = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
    prod_im = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};
    full_re = {add_re[PW], add_re} + {prod_re[PW], prod_re};
    full_im = {add_im[PW], add_im} + {prod_im[PW], prod_im};
    rnd_re  = round_half_up(full_re);
    rnd_im  = round_half_up(full_im);
  end

  assign sum_re  = full_re[PW:0];
  assign sum_im  = full_im[PW:0];
  assign res_re  = reduce(rnd_re);
  assign res_im  = reduce(rnd_im);
  assign sat_hit = out_of_range(rnd_re) || out_of_range(rnd_im);

endmodule

// File: rtl/mtx_accum.sv
// 2x2 complex state matrix M with registered element reads and IDENT/COPY/MULT
// update commands from a staging matrix G. MTX_SAT_EN enables clamping plus sticky ovf.
module mtx_accum
  import mtx_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic         wr_row,
  input  logic         wr_col,
  input  logic [W-1:0] wr_real,
  input  logic [W-1:0] wr_imag,
  input  logic         cmd_valid,
  input  logic [1:0]   cmd_op,
  output logic         cmd_ready,
  input  logic         mtx_row,
  input  logic         mtx_col,
  output logic [W-1:0] mtx_real,
  output logic [W-1:0] mtx_imag,
  output logic         mtx_ready,
  output logic         ovf
);

  state_e     state_q, state_d;
  logic [1:0] e_q;
  logic       k_q;
  logic [1:0] op_q;
  logic       accept;

  mat_t m_q, g_q, r_q;
  logic signed [2*W:0] acc_re_q, acc_im_q;
  logic signed [2*W:0] sum_re, sum_im;
  logic signed [W-1:0] res_re, res_im;
  logic                sat_hit;

  assign accept    = cmd_valid && (state_q == ST_IDLE);
  assign cmd_ready = (state_q == ST_IDLE);
  assign mtx_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = (cmd_op == OP_MULT) ? ST_MAC : ST_COMMIT;
      ST_MAC:    if (k_q && (e_q == 2'd3)) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      e_q     <= 2'd0;
      k_q     <= 1'b0;
      op_q    <= OP_IDENT;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= cmd_op;
        e_q  <= 2'd0;
        k_q  <= 1'b0;
      end else if (state_q == ST_MAC) begin
        k_q <= ~k_q;
        if (k_q) e_q <= e_q + 2'd1;
      end
    end
  end

  // Staging matrix: only writable while idle so MULT sees a stable G
  always_ff @(posedge clk) begin
    if (reset) begin
      g_q <= MAT_ZERO;
    end else if (wr_en && (state_q == ST_IDLE)) begin
      g_q[wr_row][wr_col] <= '{re: wr_real, im: wr_imag};
    end
  end

  // MAC stage: k=0 loads the accumulator, k=1 finishes the element into R
  cplx_mul_round u_mul (
    .a_re    (g_q[e_q[1]][k_q].re),
    .a_im    (g_q[e_q[1]][k_q].im),
    .b_re    (m_q[k_q][e_q[0]].re),
    .b_im    (m_q[k_q][e_q[0]].im),
    .add_re  (k_q ? acc_re_q : '0),
    .add_im  (k_q ? acc_im_q : '0),
    .sum_re  (sum_re),
    .sum_im  (sum_im),
    .res_re  (res_re),
    .res_im  (res_im),
    .sat_hit (sat_hit)
  );

  always_ff @(posedge clk) begin
    if (state_q == ST_MAC) begin
      if (!k_q) begin
        acc_re_q <= sum_re;
        acc_im_q <= sum_im;
      end else begin
        r_q[e_q[1]][e_q[0]] <= '{re: res_re, im: res_im};
      end
    end
  end

  // Commit stage: M changes only here, so reads during MAC see the old M
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q <= MAT_IDENT;
    end else if (state_q == ST_COMMIT) begin
      unique case (op_q)
        OP_IDENT: m_q <= MAT_IDENT;
        OP_COPY:  m_q <= g_q;
        OP_MULT:  m_q <= r_q;
        default:  m_q <= m_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtx_real <= '0;
      mtx_imag <= '0;
    end else begin
      mtx_real <= m_q[mtx_row][mtx_col].re;
      mtx_imag <= m_q[mtx_row][mtx_col].im;
    end
  end

`ifdef MTX_SAT_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if ((state_q == ST_MAC) && k_q && sat_hit) begin
      ovf_q <= 1'b1;
    end
  end
  assign ovf = ovf_q;
`else
  logic sat_unused;
  assign sat_unused = sat_hit;
  assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_mtx_accum.sv
// Randomized self-checking bench for mtx_accum against an integer matrix model.
// Honors MTX_SAT_EN the same way as the design build.
module tb_mtx_accum;
  import mtx_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wr_en = 1'b0, wr_row = 1'b0, wr_col = 1'b0;
  logic [W-1:0] wr_real = '0, wr_imag = '0;
  logic         cmd_valid = 1'b0;
  logic [1:0]   cmd_op = 2'd0;
  logic         cmd_ready;
  logic         mtx_row = 1'b0, mtx_col = 1'b0;
  logic [W-1:0] mtx_real, mtx_imag;
  logic         mtx_ready, ovf;

  int checks = 0;
  int errors = 0;

  longint g_re[2][2], g_im[2][2], m_re[2][2], m_im[2][2];
  bit     ovf_m;

  mtx_accum dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_real(wr_real), .wr_imag(wr_imag),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .mtx_row(mtx_row), .mtx_col(mtx_col),
    .mtx_real(mtx_real), .mtx_imag(mtx_imag),
    .mtx_ready(mtx_ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sx19(input logic [18:0] v);
    return longint'($signed(v));
  endfunction

  // Round half-up, then clamp or wrap to 19 bits as a signed integer.
  function automatic longint fix(input longint s);
    longint r;
    r = (s + 65536) >>> 17;
`ifdef MTX_SAT_EN
    if (r > 262143)  begin ovf_m = 1'b1; return 262143;  end
    if (r < -262144) begin ovf_m = 1'b1; return -262144; end
    return r;
`else
    return ((r & 'h7FFFF) ^ 'h40000) - 'h40000;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        g_re[i][j] = 0; g_im[i][j] = 0;
        m_re[i][j] = (i == j) ? 131072 : 0; m_im[i][j] = 0;
      end
    ovf_m = 1'b0;
  endtask

  task automatic model_apply(input logic [1:0] op);
    longint nr[2][2], ni[2][2];
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        longint sr, si;
        sr = 0; si = 0;
        for (int k = 0; k < 2; k++) begin
          sr += g_re[i][k] * m_re[k][j] - g_im[i][k] * m_im[k][j];
          si += g_re[i][k] * m_im[k][j] + g_im[i][k] * m_re[k][j];
        end
        case (op)
          2'd0: begin nr[i][j] = (i == j) ? 131072 : 0; ni[i][j] = 0; end
          2'd1: begin nr[i][j] = g_re[i][j]; ni[i][j] = g_im[i][j]; end
          2'd2: begin nr[i][j] = fix(sr); ni[i][j] = fix(si); end
          default: begin nr[i][j] = m_re[i][j]; ni[i][j] = m_im[i][j]; end
        endcase
      end
    m_re = nr;
    m_im = ni;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_g(input bit r, input bit c, input logic [18:0] re, input logic [18:0] im);
    wr_en = 1'b1; wr_row = r; wr_col = c; wr_real = re; wr_imag = im;
    step();
    wr_en = 1'b0;
    g_re[r][c] = sx19(re);
    g_im[r][c] = sx19(im);
  endtask

  task automatic check_m(input string tag);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        mtx_row = i[0]; mtx_col = j[0];
        step();
        check($sformatf("%s_m%0d%0d_re", tag, i, j), sx19(mtx_real), m_re[i][j]);
        check($sformatf("%s_m%0d%0d_im", tag, i, j), sx19(mtx_imag), m_im[i][j]);
      end
    check({tag, "_ovf"}, ovf, ovf_m);
  endtask

  // Issue one command and wait for commit; optionally disturb mid-MULT.
  task automatic do_cmd(input logic [1:0] op, input bit disturb);
    int     n;
    longint pre_re;
    check("cmd_ready_idle", cmd_ready, 1);
    mtx_row = 1'b0; mtx_col = 1'b0;
    pre_re = m_re[0][0];
    cmd_valid = 1'b1; cmd_op = op;
    step();
    cmd_valid = 1'b0;
    check("mtx_ready_busy", mtx_ready, 0);
    check("cmd_ready_busy", cmd_ready, 0);
    n = 0;
    while (!mtx_ready && n < 20) begin
      if (disturb && n == 2) begin
        wr_en = 1'b1; wr_row = 1'b0; wr_col = 1'b0; wr_real = 19'h12345; wr_imag = '0;
        cmd_valid = 1'b1; cmd_op = OP_IDENT;
      end
      step();
      n++;
      wr_en = 1'b0; cmd_valid = 1'b0;
      if (disturb && n == 4) check("busy_read", sx19(mtx_real), pre_re);
    end
    check("busy_cycles", n, (op == OP_MULT) ? 9 : 1);
    check("commit_edge_read", sx19(mtx_real), pre_re);
    model_apply(op);
  endtask

  initial begin
    model_reset();
    step(); step();
    reset = 1'b0;
    check("rst_real", mtx_real, 0);
    check("rst_imag", mtx_imag, 0);
    check("rst_mtx_ready", mtx_ready, 1);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_ovf", ovf, 0);
    mtx_row = 1'b0; mtx_col = 1'b0; step();
    check("rd00_re", mtx_real, 'h20000);
    check("rd00_im", mtx_imag, 0);
    mtx_col = 1'b1; step();
    check("rd01_re", mtx_real, 0);
    check("rd01_im", mtx_imag, 0);

    // Hadamard: G*I = G, then G*G = I after rounding
    wr_g(0, 0, 19'h16A0A, '0);
    wr_g(0, 1, 19'h16A0A, '0);
    wr_g(1, 0, 19'h16A0A, '0);
    wr_g(1, 1, 19'h695F6, '0);
    do_cmd(OP_MULT, 1'b0);
    check_m("had1");
    check("had1_m11_fixed", m_re[1][1], sx19(19'h695F6));
    do_cmd(OP_MULT, 1'b0);
    check_m("had2");
    check("had2_m00_fixed", m_re[0][0], 131072);

    // 1.5 squared overflows the format
    wr_g(0, 0, 19'h30000, '0);
    wr_g(0, 1, '0, '0);
    wr_g(1, 0, '0, '0);
    wr_g(1, 1, 19'h30000, '0);
    do_cmd(OP_COPY, 1'b0);
    do_cmd(OP_MULT, 1'b0);
    check_m("diag");
`ifdef MTX_SAT_EN
    check("diag_sat_fixed", m_re[0][0], 262143);
`else
    check("diag_wrap_fixed", m_re[0][0], sx19(19'h48000));
`endif

    // Dropped write and ignored command during a busy period
    wr_g(0, 0, 19'h01000, 19'h7F000);
    do_cmd(OP_MULT, 1'b1);
    check_m("dist_mult");
    do_cmd(OP_COPY, 1'b0);
    check_m("dist_copy");

    for (int it = 0; it < 16; it++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        logic [18:0] vr, vi;
        if ($urandom_range(0, 1) == 1) begin
          vr = 19'($urandom); vi = 19'($urandom);
        end else begin
          vr = 19'($signed(19'($urandom_range(0, 'h1FFFF))) - 19'sh10000);
          vi = 19'($signed(19'($urandom_range(0, 'h1FFFF))) - 19'sh10000);
        end
        wr_g(1'($urandom), 1'($urandom), vr, vi);
      end
      do_cmd(2'($urandom_range(0, 3)), 1'b0);
      check_m($sformatf("rnd%0d", it));
    end

    // Reset in the middle of a MULT
    wr_g(0, 1, 19'h05555, 19'h7AAAA);
    cmd_valid = 1'b1; cmd_op = OP_MULT;
    step();
    cmd_valid = 1'b0;
    step(); step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    check("abort_mtx_ready", mtx_ready, 1);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_ovf", ovf, 0);
    check_m("abort_m");
    do_cmd(OP_COPY, 1'b0);
    check_m("abort_g");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
